ladybird_uart_tx: RTL and testbench

Serial transmitter that drains a valid/ready byte stream, typically the read side of a `ladybird_fifo`, onto an asynchronous UART line. Frames are 1 start bit, DATA_W data bits sent LSB first, no parity, and STOP_BITS stop bits. Bit time is a fixed integer number of clk cycles. It is the transmit half of the core's console/debug UART; a matching receiver follows later and shares the package.

---
 rtl/ladybird_uart_pkg.sv | 19 +
 rtl/ladybird_uart_baud.sv | 34 +++
 rtl/ladybird_uart_tx.sv | 136 +++++++++++++
 tb/tb_ladybird_uart_tx.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/ladybird_uart_pkg.sv
// Shared types and constants for the ladybird console UART (transmitter now, receiver later).
package ladybird_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // 115200 baud from a 100 MHz core clock.
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  // Counter width for a value range 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ladybird_uart_baud.sv
// Reloadable bit-time down-counter; tick is high while the count sits at zero.
// A load restarts a full bit period, the count then holds at zero until the next load.
module ladybird_uart_baud
  import ladybird_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic anrst,
  input  logic nrst,
  input  logic load,
  output logic tick
);

  localparam int                CNT_W  = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      r_cnt <= '0;
    end else if (!nrst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= RELOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign tick = (r_cnt == '0);

endmodule

// File: rtl/ladybird_uart_tx.sv
// UART transmitter: drains a valid/ready byte stream onto txd as start, DATA_W bits LSB first, stop bit(s).
// txd is registered; s_ready opens only in IDLE or the last cycle of the final stop bit.
module ladybird_uart_tx
  import ladybird_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_W       = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              anrst,
  input  logic              nrst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              txd,
  output logic              busy
);

  localparam int               BIT_W     = cnt_width(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_t       r_state;
  uart_state_t       w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [BIT_W-1:0]  w_bit_cnt_nxt;
  logic              r_stop_cnt;
  logic              w_stop_cnt_nxt;
  logic              r_txd;
  logic              w_txd_nxt;
  logic              w_tick;
  logic              w_load;
  logic              w_final_stop;
  logic              w_accept;

  ladybird_uart_baud #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .anrst (anrst),
    .nrst  (nrst),
    .load  (w_load),
    .tick  (w_tick)
  );

  // Opening the handshake in the last stop cycle lets frames run back to back.
  assign w_final_stop = (r_state == STOP) && (r_stop_cnt == LAST_STOP) && w_tick;
  assign s_ready      = anrst & nrst & ((r_state == IDLE) | w_final_stop);
  assign w_accept     = s_valid & s_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_stop_cnt_nxt = r_stop_cnt;
    w_load         = 1'b0;

    case (r_state)
      IDLE: begin
      end
      START: begin
        if (w_tick) begin
          w_state_nxt   = DATA;
          w_bit_cnt_nxt = '0;
          w_load        = 1'b1;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shift_nxt   = r_shift >> 1;
          w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
          w_load        = 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
            w_state_nxt    = STOP;
            w_stop_cnt_nxt = 1'b0;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_stop_cnt != LAST_STOP) begin
            w_stop_cnt_nxt = r_stop_cnt + 1'b1;
            w_load         = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (w_accept) begin
      w_state_nxt = START;
      w_shift_nxt = s_data;
      w_load      = 1'b1;
    end

    // The line level is derived from the next state so txd changes on the same edge as the FSM.
    case (w_state_nxt)
      START:   w_txd_nxt = 1'b0;
      DATA:    w_txd_nxt = w_shift_nxt[0];
      default: w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_txd      <= 1'b1;
    end else if (!nrst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_txd      <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
      r_txd      <= w_txd_nxt;
    end
  end

  assign txd  = r_txd;
  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_ladybird_uart_tx.sv
// Directed bench for ladybird_uart_tx at 4 clocks per bit: one-stop and two-stop instances.
module tb_ladybird_uart_tx;

  logic       clk;
  logic       anrst;
  logic       nrst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       txd;
  logic       busy;
  logic [7:0] s_data2;
  logic       s_valid2;
  logic       s_ready2;
  logic       txd2;
  logic       busy2;

  int checks = 0;
  int errors = 0;

  ladybird_uart_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .STOP_BITS(1)) dut (
    .clk     (clk),
    .anrst   (anrst),
    .nrst    (nrst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .txd     (txd),
    .busy    (busy)
  );

  ladybird_uart_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .STOP_BITS(2)) dut2 (
    .clk     (clk),
    .anrst   (anrst),
    .nrst    (nrst),
    .s_data  (s_data2),
    .s_valid (s_valid2),
    .s_ready (s_ready2),
    .txd     (txd2),
    .busy    (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks cycles 1..last of a one-stop frame carrying b; in cycle 1 the inputs move to nv/nd.
  task automatic frame(input string name, input logic [7:0] b, input logic nv,
                       input logic [7:0] nd, input int last);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      check($sformatf("%s txd k=%0d", name, k), 32'(txd), 32'(fr[(k-1)/4]));
      check($sformatf("%s busy k=%0d", name, k), 32'(busy), 32'd1);
      check($sformatf("%s s_ready k=%0d", name, k), 32'(s_ready), 32'(k == 40));
      if (k == 1) begin
        s_valid = nv;
        s_data  = nd;
      end
    end
  endtask

  task automatic idle_check(input string name);
    @(negedge clk);
    check({name, " idle txd"}, 32'(txd), 32'd1);
    check({name, " idle busy"}, 32'(busy), 32'd0);
    check({name, " idle s_ready"}, 32'(s_ready), 32'd1);
  endtask

  initial begin
    logic [10:0] fr2;

    anrst    = 1'b0;
    nrst     = 1'b1;
    s_valid  = 1'b1;
    s_data   = 8'h5A;
    s_valid2 = 1'b1;
    s_data2  = 8'h5A;

    // 1: reset held with s_valid high
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst txd", 32'(txd), 32'd1);
      check("rst s_ready", 32'(s_ready), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst txd2", 32'(txd2), 32'd1);
      check("rst s_ready2", 32'(s_ready2), 32'd0);
      check("rst busy2", 32'(busy2), 32'd0);
    end
    s_valid  = 1'b0;
    s_valid2 = 1'b0;
    anrst    = 1'b1;
    #1;
    check("post-rst s_ready", 32'(s_ready), 32'd1);
    check("post-rst s_ready2", 32'(s_ready2), 32'd1);

    // 2: single byte 0xA5
    s_valid = 1'b1;
    s_data  = 8'hA5;
    frame("a5", 8'hA5, 1'b0, 8'h00, 40);
    idle_check("a5");

    // 3: back-to-back 0x00 then 0xFF
    s_valid = 1'b1;
    s_data  = 8'h00;
    frame("b2b0", 8'h00, 1'b1, 8'hFF, 40);
    frame("b2b1", 8'hFF, 1'b0, 8'h00, 40);
    idle_check("b2b");

    // 4: backpressure, data changes under a held s_valid
    s_valid = 1'b1;
    s_data  = 8'h3C;
    frame("bp0", 8'h3C, 1'b1, 8'hFF, 40);
    frame("bp1", 8'hFF, 1'b0, 8'h00, 40);
    idle_check("bp");

    // 5: nrst pulse during data bit 3 (cycles 17..20)
    s_valid = 1'b1;
    s_data  = 8'h77;
    frame("nrst", 8'h77, 1'b0, 8'h00, 18);
    nrst = 1'b0;
    @(negedge clk);
    check("nrst txd", 32'(txd), 32'd1);
    check("nrst busy", 32'(busy), 32'd0);
    check("nrst s_ready", 32'(s_ready), 32'd0);
    nrst = 1'b1;
    #1;
    check("nrst release s_ready", 32'(s_ready), 32'd1);
    s_valid = 1'b1;
    s_data  = 8'h81;
    frame("x81", 8'h81, 1'b0, 8'h00, 40);
    idle_check("x81");

    // 6: two stop bits, 0x55
    fr2      = {2'b11, 8'h55, 1'b0};
    s_valid2 = 1'b1;
    s_data2  = 8'h55;
    for (int k = 1; k <= 44; k++) begin
      @(negedge clk);
      check($sformatf("stop2 txd k=%0d", k), 32'(txd2), 32'(fr2[(k-1)/4]));
      check($sformatf("stop2 busy k=%0d", k), 32'(busy2), 32'd1);
      check($sformatf("stop2 s_ready k=%0d", k), 32'(s_ready2), 32'(k == 44));
      if (k == 1) s_valid2 = 1'b0;
    end
    @(negedge clk);
    check("stop2 idle txd", 32'(txd2), 32'd1);
    check("stop2 idle busy", 32'(busy2), 32'd0);
    check("stop2 idle s_ready", 32'(s_ready2), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
